// File: rtl/alu_mdu_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
// Opcode encoding follows RV32M funct3; state enum covers the iterative FSM.
package alu_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_mdu_step.sv
// One radix-2 iteration: shift-add multiply on {hi, multiplier}, restoring divide on {rem, quot}.
// Purely combinational; no handshake.
module alu_mdu_step #(
    parameter int XLEN = 32
) (
    input  logic              div_mode_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] rem_diff;

    assign add_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
    // Remainder after the left shift needs XLEN+1 bits; the diff MSB is the borrow.
    assign rem_sh   = acc_i[2*XLEN-1:XLEN-1];
    assign rem_diff = rem_sh - {1'b0, opnd_i};

    always_comb begin
        acc_o = '0;
        if (div_mode_i) begin
            if (!rem_diff[XLEN]) begin
                acc_o = {rem_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*XLEN-2:0], 1'b0};
            end
        end else if (acc_i[0]) begin
            acc_o = {add_sum, acc_i[XLEN-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_mdu_iter.sv
// Iterative RV32M MUL/DIV unit: XLEN+2 cycles accept-to-result, 1 cycle for div-by-zero/overflow.
// Holds the result in DONE until i_ready; accepts only in IDLE; i_flush aborts from any state.
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_operand_a,
    input  logic [XLEN-1:0]  i_operand_b,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_tag
);

    localparam int CW = $clog2(XLEN);

    mdu_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic              neg_q;
    logic [XLEN-1:0]   result_q;
    logic              valid_q;

    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   fix_d;
    logic [XLEN-1:0]   fast_res_d;
    logic              sa_d, sb_d, neg_d, div_zero_d, ovf_d;
    logic [XLEN-1:0]   mag_a_d, mag_b_d;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s;

    assign sa_d    = a_signed(i_funct3) & i_operand_a[XLEN-1];
    assign sb_d    = b_signed(i_funct3) & i_operand_b[XLEN-1];
    assign mag_a_d = sa_d ? -i_operand_a : i_operand_a;
    assign mag_b_d = sb_d ? -i_operand_b : i_operand_b;
    // Remainder takes the dividend sign; product and quotient take sa^sb.
    assign neg_d   = (is_div(i_funct3) && i_funct3[1]) ? sa_d : (sa_d ^ sb_d);

    assign div_zero_d = is_div(i_funct3) && (i_operand_b == '0);
    assign ovf_d      = ((i_funct3 == OP_DIV) || (i_funct3 == OP_REM))
                        && (i_operand_a == {1'b1, {(XLEN-1){1'b0}}})
                        && (i_operand_b == '1);
    assign fast_res_d = div_zero_d ? (i_funct3[1] ? i_operand_a : '1)
                                   : (i_funct3[1] ? '0 : i_operand_a);

    alu_mdu_step #(.XLEN(XLEN)) u_step (
        .div_mode_i (is_div(op_q)),
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .acc_o      (acc_d)
    );

    assign prod_s = neg_q ? -acc_q : acc_q;
    assign quot_s = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_d = '0;
        case (op_q)
            OP_MUL:                     fix_d = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_d = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            fix_d = quot_s;
            default:                    fix_d = rem_s;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (i_flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (i_valid) begin
                    op_q   <= i_funct3;
                    tag_q  <= i_tag;
                    acc_q  <= {{XLEN{1'b0}}, mag_a_d};
                    opnd_q <= mag_b_d;
                    neg_q  <= neg_d;
                    cnt_q  <= '0;
                    if (div_zero_d || ovf_d) begin
                        result_q <= fast_res_d;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == CW'(XLEN-1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    result_q <= fix_d;
                    valid_q  <= 1'b1;
                    state_q  <= ST_DONE;
                end
                default: if (i_ready) begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_tag    = tag_q;

endmodule
